// File: rtl/bp_pma_arbiter_pkg.sv
// Configuration helpers and the result-record declaration macro shared by the PMA arbiter slice.
// Address widths are derived from the processor configuration enum so callers select a single configuration.
`define BSG_SAFE_CLOG2(x) (((x) > 1) ? $clog2(x) : 1)

`define DECLARE_BP_PMA_RESP_S(num_req_mp) \
    typedef struct packed { \
        logic [`BSG_SAFE_CLOG2(num_req_mp)-1:0] id; \
        logic uncached; \
        logic nonidem; \
        logic dram; \
    } bp_pma_resp_s

package bp_pma_arbiter_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_cfg_e;

    localparam int page_offset_width_gp = 12;

    function automatic int cfg_ptag_width(input bp_cfg_e cfg);
        case (cfg)
            e_bp_default_cfg: return 28;
            default:          return 28;
        endcase
    endfunction

    function automatic int cfg_dtag_width(input bp_cfg_e cfg);
        case (cfg)
            e_bp_default_cfg: return 21;
            default:          return 21;
        endcase
    endfunction

    function automatic int cfg_caddr_width(input bp_cfg_e cfg);
        case (cfg)
            e_bp_default_cfg: return 32;
            default:          return 32;
        endcase
    endfunction

    function automatic logic [63:0] cfg_dram_base(input bp_cfg_e cfg);
        case (cfg)
            e_bp_default_cfg: return 64'h0000_0000_8000_0000;
            default:          return 64'h0000_0000_8000_0000;
        endcase
    endfunction

endpackage

// File: rtl/bp_pma_arbiter_rr_arb.sv
// Round-robin picker: grants the first valid requester at or after the pointer.
// The pointer only moves past a requester once its grant has actually been taken.
module bp_pma_rr_arb
    import bp_pma_arbiter_pkg::*;
#(
    parameter  int num_req_p     = 2,
    localparam int lg_num_req_lp = `BSG_SAFE_CLOG2(num_req_p)
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [num_req_p-1:0]     req_v,
    output logic [num_req_p-1:0]     grant,
    output logic [lg_num_req_lp-1:0] grant_id,
    output logic                     grant_v
);

    logic [lg_num_req_lp-1:0] rr_ptr_r;
    logic [lg_num_req_lp-1:0] rr_ptr_n;
    logic [lg_num_req_lp-1:0] idx;
    int                       sum;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        grant_v  = 1'b0;
        idx      = '0;
        sum      = 0;
        for (int k = 0; k < num_req_p; k++) begin
            sum = int'(rr_ptr_r) + k;
            if (sum >= num_req_p) begin
                sum = sum - num_req_p;
            end
            idx = lg_num_req_lp'(sum);
            if (en && req_v[idx] && !grant_v) begin
                grant_v    = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    assign rr_ptr_n = (grant_id == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
        end else if (grant_v) begin
            rr_ptr_r <= rr_ptr_n;
        end
    end

endmodule

// File: rtl/bp_pma_arbiter.sv
// Shares one PMA classifier among several requesters: round-robin grant, one lookup per cycle,
// and a single registered result with valid/ready backpressure toward the UCE/LCE issue logic.
module bp_pma_arbiter
    import bp_pma_arbiter_pkg::*;
#(
    parameter  bp_cfg_e bp_params_p   = e_bp_default_cfg,
    parameter  int      num_req_p     = 2,
    localparam int      ptag_width_p  = cfg_ptag_width(bp_params_p),
    localparam int      dtag_width_p  = cfg_dtag_width(bp_params_p),
    localparam int      caddr_width_p = cfg_caddr_width(bp_params_p),
    localparam int      lg_num_req_lp = `BSG_SAFE_CLOG2(num_req_p)
)
(
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i,
    input  logic [num_req_p-1:0]              req_uncached_mode_i,
    input  logic [num_req_p-1:0]              req_nonspec_mode_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              resp_v_o,
    output logic [lg_num_req_lp-1:0]          resp_id_o,
    output logic                              resp_uncached_o,
    output logic                              resp_nonidem_o,
    output logic                              resp_dram_o,
    input  logic                              resp_ready_i
);

    `DECLARE_BP_PMA_RESP_S(num_req_p);

    localparam logic [63:0] dram_base_addr_lp = cfg_dram_base(bp_params_p);
    localparam logic [ptag_width_p-1:0] dram_ptag_lp =
        ptag_width_p'(dram_base_addr_lp >> page_offset_width_gp);

    bp_pma_resp_s             resp_r;
    bp_pma_resp_s             resp_n;
    logic                     resp_v_r;
    logic                     reg_free;
    logic                     grant_v;
    logic [num_req_p-1:0]     grant;
    logic [lg_num_req_lp-1:0] grant_id;
    logic [ptag_width_p-1:0]  ptag;
    logic                     is_local;
    logic                     is_io;
    logic                     is_uc;
    logic                     is_uncached;

    // Same-cycle refill is allowed when the held result is being drained.
    assign reg_free = ~resp_v_r | resp_ready_i;

    bp_pma_rr_arb #(
        .num_req_p(num_req_p)
    ) rr_arb (
        .clk      (clk_i),
        .reset_n  (reset_n_i),
        .en       (reset_n_i & reg_free),
        .req_v    (req_v_i),
        .grant    (grant),
        .grant_id (grant_id),
        .grant_v  (grant_v)
    );

    assign req_ready_o = grant;

    always_comb begin
        ptag        = req_ptag_i[grant_id*ptag_width_p +: ptag_width_p];
        is_local    = (ptag < dram_ptag_lp);
        is_io       = |ptag[ptag_width_p-1:dtag_width_p];
        is_uc       = |ptag[ptag_width_p-1:caddr_width_p-page_offset_width_gp];
        is_uncached = is_uc | is_io | is_local | req_uncached_mode_i[grant_id];

        resp_n          = '0;
        resp_n.id       = grant_id;
        resp_n.uncached = is_uncached;
        resp_n.nonidem  = is_uncached | req_nonspec_mode_i[grant_id];
        resp_n.dram     = ~is_local & ~is_io & ~is_uc;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            resp_v_r <= 1'b0;
            resp_r   <= '0;
        end else if (grant_v) begin
            resp_v_r <= 1'b1;
            resp_r   <= resp_n;
        end else if (resp_ready_i) begin
            resp_v_r <= 1'b0;
        end
    end

    assign resp_v_o        = resp_v_r;
    assign resp_id_o       = resp_r.id;
    assign resp_uncached_o = resp_r.uncached;
    assign resp_nonidem_o  = resp_r.nonidem;
    assign resp_dram_o     = resp_r.dram;

endmodule

// File: tb/tb_bp_pma_arbiter.sv
// Testbench for bp_pma_arbiter: directed vector table, a reset-during-stall sequence,
// and randomized traffic checked against an address-range reference model.
module tb_bp_pma_arbiter;

    localparam int NREQ = 2;
    localparam int PW   = 28;
    localparam int unsigned DRAM_PTAG = 32'h8000_0000 / 4096;
    localparam int unsigned UC_PTAG   = 32'h1 << (32 - 12);
    localparam int unsigned IO_PTAG   = 32'h1 << (33 - 12);

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_v;
    logic [NREQ*PW-1:0] req_ptag;
    logic [NREQ-1:0]   req_ucm;
    logic [NREQ-1:0]   req_nsm;
    logic [NREQ-1:0]   req_ready;
    logic              resp_v;
    logic              resp_id;
    logic              resp_unc;
    logic              resp_ni;
    logic              resp_dram;
    logic              resp_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    bp_pma_arbiter #(
        .num_req_p(NREQ)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .req_v_i             (req_v),
        .req_ptag_i          (req_ptag),
        .req_uncached_mode_i (req_ucm),
        .req_nonspec_mode_i  (req_nsm),
        .req_ready_o         (req_ready),
        .resp_v_o            (resp_v),
        .resp_id_o           (resp_id),
        .resp_uncached_o     (resp_unc),
        .resp_nonidem_o      (resp_ni),
        .resp_dram_o         (resp_dram),
        .resp_ready_i        (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    v;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        logic [1:0]    ucm;
        logic [1:0]    nsm;
        logic          rdy;
        logic [1:0]    e_ready;
        logic          e_v;
        logic          e_id;
        logic          e_unc;
        logic          e_ni;
        logic          e_dram;
        logic          cd;
    } vec_t;

    vec_t vecs[24];

    // Reference model state: pending result and round-robin pointer.
    logic m_v;
    logic m_id;
    logic m_unc;
    logic m_ni;
    logic m_dram;
    int   m_ptr;

    task automatic applyStimulus(input logic [1:0] v, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                 input logic [1:0] ucm, input logic [1:0] nsm, input logic rdy,
                                 input logic rst_n);
        @(negedge clk);
        req_v      = v;
        req_ptag   = {p1, p0};
        req_ucm    = ucm;
        req_nsm    = nsm;
        resp_ready = rdy;
        reset_n    = rst_n;
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] e_ready, input logic e_v,
                               input logic e_id, input logic e_unc, input logic e_ni,
                               input logic e_dram, input logic cd);
        checkField({name, ".ready"}, 32'(req_ready), 32'(e_ready));
        checkField({name, ".resp_v"}, 32'(resp_v), 32'(e_v));
        if (cd) begin
            checkField({name, ".id"}, 32'(resp_id), 32'(e_id));
            checkField({name, ".uncached"}, 32'(resp_unc), 32'(e_unc));
            checkField({name, ".nonidem"}, 32'(resp_ni), 32'(e_ni));
            checkField({name, ".dram"}, 32'(resp_dram), 32'(e_dram));
        end
    endtask

    task automatic classify(input logic [PW-1:0] p, input logic um, input logic nm,
                            output logic u, output logic n, output logic d);
        int unsigned pv;
        logic below_dram;
        logic above_cached;
        pv           = 32'(p);
        below_dram   = (pv < DRAM_PTAG);
        above_cached = (pv >= UC_PTAG) || (pv >= IO_PTAG);
        u = below_dram || above_cached || um;
        n = u || nm;
        d = !below_dram && !above_cached;
    endtask

    task automatic modelExpect(input logic [1:0] v, input logic rdy, input logic rst_n,
                               output logic [1:0] er, output int g);
        er = 2'b00;
        g  = -1;
        if (rst_n && (!m_v || rdy)) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
    endtask

    task automatic modelUpdate(input int g, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                               input logic [1:0] ucm, input logic [1:0] nsm, input logic rdy,
                               input logic rst_n);
        if (!rst_n) begin
            m_v = 1'b0; m_id = 1'b0; m_unc = 1'b0; m_ni = 1'b0; m_dram = 1'b0; m_ptr = 0;
        end else if (g >= 0) begin
            m_v  = 1'b1;
            m_id = (g == 1);
            classify((g == 1) ? p1 : p0, ucm[g], nsm[g], m_unc, m_ni, m_dram);
            m_ptr = (g + 1) % NREQ;
        end else if (rdy) begin
            m_v = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]    rv;
        logic [PW-1:0] rp0;
        logic [PW-1:0] rp1;
        logic [1:0]    rucm;
        logic [1:0]    rnsm;
        logic          rrdy;
        logic          rrst;
        logic [1:0]    er;
        int            g;

        vecs[0]  = '{2'b00, 28'h0,     28'h0,      2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2'b01, 28'h80000, 28'h0,      2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 28'h0,     28'h0,      2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{2'b10, 28'h0,     28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 28'h0,     28'h200000, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 28'h0,     28'h80000,  2'b00, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'b00, 28'h0,     28'h0,      2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{2'b00, 28'h0,     28'h0,      2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{2'b00, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{2'b00, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[21] = '{2'b11, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{2'b00, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[23] = '{2'b00, 28'h80000, 28'h7FFFF,  2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        req_v = '0; req_ptag = '0; req_ucm = '0; req_nsm = '0; resp_ready = 1'b0; reset_n = 1'b0;

        // Reset held with traffic present: no grant may be offered.
        applyStimulus(2'b11, 28'h80000, 28'h80000, 2'b00, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 28'h80000, 28'h80000, 2'b00, 2'b00, 1'b1, 1'b0);
        checkOutput("reset_hold", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].v, vecs[i].p0, vecs[i].p1, vecs[i].ucm, vecs[i].nsm, vecs[i].rdy, 1'b1);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_v, vecs[i].e_id,
                        vecs[i].e_unc, vecs[i].e_ni, vecs[i].e_dram, vecs[i].cd);
        end

        // Reset while a result is stalled: result dropped and pointer back to requester 0.
        applyStimulus(2'b01, 28'h80000, 28'h7FFFF, 2'b00, 2'b00, 1'b0, 1'b1);
        checkOutput("rst_seq.grant", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b11, 28'h80000, 28'h7FFFF, 2'b00, 2'b00, 1'b0, 1'b1);
        checkOutput("rst_seq.stall", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b11, 28'h80000, 28'h7FFFF, 2'b00, 2'b00, 1'b0, 1'b0);
        checkOutput("rst_seq.in_reset", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(2'b11, 28'h80000, 28'h7FFFF, 2'b00, 2'b00, 1'b1, 1'b1);
        checkOutput("rst_seq.after", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 28'h80000, 28'h7FFFF, 2'b00, 2'b00, 1'b1, 1'b1);
        checkOutput("rst_seq.result", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic against the reference model, starting from a clean reset.
        applyStimulus(2'b00, 28'h0, 28'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        modelUpdate(-1, 28'h0, 28'h0, 2'b00, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rv   = 2'($urandom_range(0, 3));
            rucm = 2'($urandom_range(0, 3)) & {2{$urandom_range(0, 3) == 0}};
            rnsm = 2'($urandom_range(0, 3)) & {2{$urandom_range(0, 3) == 0}};
            rrdy = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 49) != 0);
            case ($urandom_range(0, 3))
                0:       rp0 = PW'($urandom_range(0, 32'h7FFFF));
                1:       rp0 = PW'($urandom_range(32'h80000, 32'hFFFFF));
                2:       rp0 = PW'($urandom_range(32'h100000, 32'h1FFFFF));
                default: rp0 = PW'($urandom_range(32'h200000, 32'hFFFFFFF));
            endcase
            case ($urandom_range(0, 3))
                0:       rp1 = PW'($urandom_range(0, 32'h7FFFF));
                1:       rp1 = PW'($urandom_range(32'h80000, 32'hFFFFF));
                2:       rp1 = PW'($urandom_range(32'h100000, 32'h1FFFFF));
                default: rp1 = PW'($urandom_range(32'h200000, 32'hFFFFFFF));
            endcase
            applyStimulus(rv, rp0, rp1, rucm, rnsm, rrdy, rrst);
            modelExpect(rv, rrdy, rrst, er, g);
            checkOutput($sformatf("rand%0d", i), er, m_v, m_id, m_unc, m_ni, m_dram, m_v);
            modelUpdate(g, rp0, rp1, rucm, rnsm, rrdy, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
